// File: rtl/matrix_io_controller.sv
// matrix_io_controller: command/operand sequencer feeding the matrix ALU and streaming its result
module matrix_io_controller #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [2:0]                      cmd_opcode,
  input  logic [2:0]                      cmd_n,
  input  logic [ELEM_W-1:0]               cmd_f,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ELEM_W-1:0]               in_data,
  output logic [MAX_N*MAX_N*ELEM_W-1:0]   A_flat,
  output logic [MAX_N*MAX_N*ELEM_W-1:0]   B_flat,
  output logic [ELEM_W-1:0]               f,
  output logic [2:0]                      opcode,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0]   C_flat,
  input  logic                            alu_ovf,
  input  logic                            alu_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ELEM_W-1:0]               out_data,
  output logic                            out_last,
  output logic                            out_ovf,
  output logic                            err
);
  localparam int FW = MAX_N * MAX_N * ELEM_W;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, SEND} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d, n_q, n_d, row_q, row_d, col_q, col_d, row_nx, col_nx;
  logic [ELEM_W-1:0] f_q, f_d, od_q, od_d;
  logic [FW-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic              ovf_q, ovf_d, ol_q, ol_d, err_q, err_d;
  logic [3:0]        tmr_q, tmr_d;
  logic [7:0]        sel, sel_nx;
  logic              cmd_ok, col_wrap, last_el, last_nx, two_op;
  assign cmd_ok    = cmd_n != 3'd0 && cmd_n <= 3'(MAX_N) && cmd_opcode != 3'd0;
  assign col_wrap  = col_q == n_q - 3'd1;
  assign row_nx    = col_wrap ? row_q + 3'd1 : row_q;
  assign col_nx    = col_wrap ? 3'd0 : col_q + 3'd1;
  assign last_el   = col_wrap && row_q == n_q - 3'd1;
  assign last_nx   = col_nx == n_q - 3'd1 && row_nx == n_q - 3'd1;
  assign sel       = 8'((int'(row_q) * MAX_N + int'(col_q)) * ELEM_W);
  assign sel_nx    = 8'((int'(row_nx) * MAX_N + int'(col_nx)) * ELEM_W);
  assign two_op    = op_q == 3'd1 || op_q == 3'd2 || op_q == 3'd3;
  assign cmd_ready = state_q == IDLE;
  assign in_ready  = state_q == LOAD_A || state_q == LOAD_B;
  assign out_valid = state_q == SEND;
  assign opcode    = state_q == EXEC ? op_q : 3'd0;
  assign out_ovf   = state_q == SEND && ovf_q;
  assign A_flat    = a_q;
  assign B_flat    = b_q;
  assign f         = f_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign err       = err_q;
  // Next-state: command intake, row-major operand fill, ALU wait with timeout, result streaming
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    f_d     = f_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    row_d   = row_q;
    col_d   = col_q;
    tmr_d   = tmr_q;
    od_d    = od_q;
    ol_d    = ol_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd_ok) begin
          op_d    = cmd_opcode;
          n_d     = cmd_n;
          f_d     = cmd_f;
          a_d     = '0;
          b_d     = '0;
          res_d   = '0;
          ovf_d   = 1'b0;
          od_d    = '0;
          ol_d    = 1'b0;
          row_d   = 3'd0;
          col_d   = 3'd0;
          state_d = LOAD_A;
        end else begin
          err_d = 1'b1;
        end
      end
      LOAD_A, LOAD_B: if (in_valid) begin
        if (state_q == LOAD_A) a_d[sel +: ELEM_W] = in_data;
        else b_d[sel +: ELEM_W] = in_data;
        row_d = last_el ? 3'd0 : row_nx;
        col_d = last_el ? 3'd0 : col_nx;
        tmr_d = 4'd0;
        if (last_el) state_d = (state_q == LOAD_A && two_op) ? LOAD_B : EXEC;
      end
      EXEC: begin
        tmr_d = tmr_q + 4'd1;
        if (alu_done) begin
          res_d   = C_flat;
          ovf_d   = alu_ovf;
          od_d    = C_flat[ELEM_W-1:0];
          ol_d    = op_q == 3'd7 || n_q == 3'd1;
          row_d   = 3'd0;
          col_d   = 3'd0;
          state_d = SEND;
        end else if (tmr_q == 4'd15) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: if (out_ready) begin
        if (ol_q) begin
          od_d    = '0;
          ol_d    = 1'b0;
          state_d = IDLE;
        end else begin
          row_d = row_nx;
          col_d = col_nx;
          od_d  = res_q[sel_nx +: ELEM_W];
          ol_d  = last_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      n_q     <= '0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      tmr_q   <= '0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmr_q   <= tmr_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_matrix_io_controller.sv
// tb_matrix_io_controller: directed checks of command, load, exec, send, error and reset paths
module tb_matrix_io_controller;
  logic         clk = 1'b0, rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [2:0]   cmd_opcode = '0, cmd_n = '0;
  logic [7:0]   cmd_f = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [7:0]   in_data = '0;
  logic [199:0] A_flat, B_flat, C_flat = '0;
  logic [7:0]   f;
  logic [2:0]   opcode;
  logic         alu_ovf = 1'b0, alu_done = 1'b0;
  logic         out_valid, out_ready = 1'b0, out_last, out_ovf, err;
  logic [7:0]   out_data;
  int           n_cmp = 0, n_err = 0;

  matrix_io_controller dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_n(cmd_n), .cmd_f(cmd_f),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .A_flat(A_flat), .B_flat(B_flat), .f(f), .opcode(opcode),
    .C_flat(C_flat), .alu_ovf(alu_ovf), .alu_done(alu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_ovf(out_ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [2:0] n, input logic [7:0] ff);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_n = n; cmd_f = ff;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    chk("in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic done_alu(input logic ovf);
    alu_ovf = ovf; alu_done = 1'b1;
    step();
    alu_done = 1'b0;
  endtask

  task automatic pull(input logic [7:0] d, input logic last, input logic ovf);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, d);
    chk("out_last", out_last, last);
    chk("out_ovf", out_ovf, ovf);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_A", A_flat, 0);
    chk("rst_out_data", out_data, 0);
    step(); step();
    rst = 1'b0;
    step();
    // add, n=2
    cmd(3'd1, 3'd2, 8'd0);
    chk("add_cmd_ready", cmd_ready, 0);
    push(8'd1); push(8'd2);
    chk("add_A0", A_flat[7:0], 1);
    chk("add_A1", A_flat[15:8], 2);
    push(8'd3); push(8'd4);
    chk("add_A5", A_flat[47:40], 3);
    chk("add_A6", A_flat[55:48], 4);
    chk("add_A_rest", A_flat[199:56] | A_flat[39:16], 0);
    chk("add_opcode_load", opcode, 0);
    push(8'd10); push(8'd20); push(8'd30); push(8'd40);
    chk("add_B5", B_flat[47:40], 30);
    chk("add_B6", B_flat[55:48], 40);
    chk("add_opcode_exec", opcode, 1);
    chk("add_in_ready_exec", in_ready, 0);
    C_flat = '0;
    C_flat[7:0] = 8'd11; C_flat[15:8] = 8'd22; C_flat[47:40] = 8'd33; C_flat[55:48] = 8'd44;
    C_flat[23:16] = 8'd99;
    done_alu(1'b0);
    chk("add_opcode_send", opcode, 0);
    pull(8'd11, 0, 0); pull(8'd22, 0, 0); pull(8'd33, 0, 0); pull(8'd44, 1, 0);
    chk("add_cmd_ready_end", cmd_ready, 1);
    chk("add_out_valid_end", out_valid, 0);
    // determinant, n=2, stalled
    cmd(3'd7, 3'd2, 8'd0);
    push(8'd3); push(8'd1); push(8'd2); push(8'd4);
    chk("det_opcode", opcode, 7);
    chk("det_B", B_flat, 0);
    C_flat = '0; C_flat[7:0] = 8'd10; C_flat[15:8] = 8'd77;
    done_alu(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("det_stall_valid", out_valid, 1);
      chk("det_stall_data", out_data, 10);
      chk("det_stall_last", out_last, 1);
      step();
    end
    pull(8'd10, 1, 0);
    chk("det_cmd_ready", cmd_ready, 1);
    // scalar, n=3, f=2, overflow
    cmd(3'd4, 3'd3, 8'd2);
    for (int i = 0; i < 9; i++) push(8'd100);
    chk("scl_opcode", opcode, 4);
    chk("scl_f", f, 2);
    chk("scl_A8", A_flat[103:96], 100);
    chk("scl_A_out", A_flat[39:24], 0);
    C_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) C_flat[(r*5+c)*8 +: 8] = 8'(r*3 + c + 1);
    done_alu(1'b1);
    for (int i = 0; i < 9; i++) pull(8'(i + 1), i == 8, 1);
    chk("scl_idle", cmd_ready, 1);
    chk("scl_ovf_idle", out_ovf, 0);
    // invalid n=6
    cmd(3'd1, 3'd6, 8'd0);
    chk("inv_n_err", err, 1);
    chk("inv_n_in_ready", in_ready, 0);
    chk("inv_n_cmd_ready", cmd_ready, 1);
    step();
    chk("inv_n_err_clr", err, 0);
    // invalid opcode 000
    cmd(3'd0, 3'd2, 8'd0);
    chk("inv_op_err", err, 1);
    chk("inv_op_in_ready", in_ready, 0);
    step();
    chk("inv_op_err_clr", err, 0);
    chk("inv_op_in_ready2", in_ready, 0);
    // abort with reset mid-B
    cmd(3'd1, 3'd2, 8'd0);
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
    push(8'd5); push(8'd6);
    chk("abt_B0", B_flat[7:0], 5);
    #2 rst = 1'b1;
    #1;
    chk("abt_A", A_flat, 0);
    chk("abt_B", B_flat, 0);
    chk("abt_cmd_ready", cmd_ready, 1);
    chk("abt_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    step();
    cmd(3'd1, 3'd1, 8'd0);
    push(8'd5); push(8'd6);
    chk("abt2_opcode", opcode, 1);
    C_flat = '0; C_flat[7:0] = 8'd11;
    done_alu(1'b0);
    pull(8'd11, 1, 0);
    chk("abt2_idle", cmd_ready, 1);
    // timeout
    cmd(3'd4, 3'd1, 8'd3);
    push(8'd7);
    chk("to_opcode_entry", opcode, 4);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_wait_err", err, 0);
      chk("to_wait_opcode", opcode, 4);
    end
    step();
    chk("to_err", err, 1);
    chk("to_opcode", opcode, 0);
    chk("to_out_valid", out_valid, 0);
    chk("to_cmd_ready", cmd_ready, 1);
    step();
    chk("to_err_clr", err, 0);
    chk("to_out_valid2", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
